// File: rtl/recv_string_pkg.sv
// Shared constants and state encoding for the line receiver.
package recv_string_pkg;

    localparam logic [7:0] CHAR_CR = 8'h0d;
    localparam logic [7:0] CHAR_BS = 8'h08;
    localparam logic [7:0] CHAR_SP = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        COMMIT
    } state_t;

endpackage

// File: rtl/recv_string.sv
// Line receiver: assembles up to seven bytes into a shadow line and
// commits it to double-buffered parallel outputs on carriage return.
module recv_string
    import recv_string_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR = CHAR_CR,
    parameter logic [7:0] BS_CHAR   = CHAR_BS,
    parameter logic [7:0] PAD_CHAR  = CHAR_SP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dIn,
    input  logic       dValid,
    output logic [7:0] b0,
    output logic [7:0] b1,
    output logic [7:0] b2,
    output logic [7:0] b3,
    output logic [7:0] b4,
    output logic [7:0] b5,
    output logic [7:0] b6,
    output logic [2:0] len,
    output logic       done,
    output logic       busy,
    output logic       ovf
);

    state_t     state_q, state_d;
    logic [7:0] sh_q [7];
    logic [7:0] sh_d [7];
    logic [7:0] bq   [7];
    logic [2:0] cnt_q, cnt_d;
    logic       ovfp_q, ovfp_d;
    logic [2:0] len_q;
    logic       ovf_q;
    logic       is_term;
    logic       is_bs;
    logic       commit;

    assign is_term = (dIn == TERM_CHAR);
    assign is_bs   = (dIn == BS_CHAR);

    // The shadow is cleared on the same edge the terminator is accepted,
    // so a byte arriving during COMMIT starts the next line at slot 0.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        ovfp_d  = ovfp_q;
        commit  = 1'b0;
        if (state_q == COMMIT) begin
            state_d = IDLE;
        end
        if (dValid) begin
            unique case (1'b1)
                is_term: begin
                    commit  = 1'b1;
                    state_d = COMMIT;
                    for (int i = 0; i < 7; i++) begin
                        sh_d[i] = PAD_CHAR;
                    end
                    cnt_d  = 3'd0;
                    ovfp_d = 1'b0;
                end
                is_bs: begin
                    state_d = RECV;
                    if (cnt_q != 3'd0) begin
                        cnt_d             = cnt_q - 3'd1;
                        sh_d[cnt_q-3'd1] = PAD_CHAR;
                    end
                end
                default: begin
                    state_d = RECV;
                    if (cnt_q == 3'd7) begin
                        ovfp_d = 1'b1;
                    end else begin
                        sh_d[cnt_q] = dIn;
                        cnt_d       = cnt_q + 3'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            ovfp_q  <= 1'b0;
            len_q   <= 3'd0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                sh_q[i] <= PAD_CHAR;
                bq[i]   <= PAD_CHAR;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovfp_q  <= ovfp_d;
            sh_q    <= sh_d;
            if (commit) begin
                len_q <= cnt_q;
                ovf_q <= ovfp_q;
                for (int i = 0; i < 7; i++) begin
                    bq[i] <= (3'(i) < cnt_q) ? sh_q[i] : PAD_CHAR;
                end
            end
        end
    end

    assign b0   = bq[0];
    assign b1   = bq[1];
    assign b2   = bq[2];
    assign b3   = bq[3];
    assign b4   = bq[4];
    assign b5   = bq[5];
    assign b6   = bq[6];
    assign len  = len_q;
    assign ovf  = ovf_q;
    assign done = (state_q == COMMIT);
    assign busy = (state_q == RECV);

endmodule

// File: doc/recv_string.md
# recv_string

Line receiver for the lab display/terminal path: accepts a byte stream one character per strobe, assembles up to seven characters into a shadow line buffer, and commits the line to seven parallel byte outputs when the terminator (carriage return, 8'h0d) arrives. It is the receive-side counterpart of the team's string sender, which emits seven bytes followed by 8'h0d. The parallel outputs are double-buffered: they hold the last completed line and never show a partial line.

## Interface
- TERM_CHAR, 8'h0d: line terminator.
- BS_CHAR, 8'h08: backspace; removes the last stored character.
- PAD_CHAR, 8'h20: fill value for unused output positions.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-high.
- dIn  in  8  received byte; sampled only when dValid=1.
- dValid  in  1  byte strobe; each cycle high = one byte.
- b0..b6  out  8 each  committed line, b0 = first character.
- len  out  3  number of valid characters in committed line (0..7).
- done  out  1  one-cycle pulse: new line committed this cycle.
- busy  out  1  a line is in progress (at least one non-terminator byte accepted, terminator not yet seen).
- ovf  out  1  committed line had more than 7 characters; extras dropped.

## Operation
- States: IDLE (no line in progress), RECV (collecting), COMMIT (one cycle, drives done).
- IDLE, dValid, dIn != TERM_CHAR: go to RECV and process the byte as below. IDLE, dValid, dIn == TERM_CHAR: go to COMMIT with an empty line.
- RECV, dValid:
  - Ordinary byte with cnt<7: shadow[cnt] <= dIn, cnt++.
  - Ordinary byte with cnt==7: byte dropped, ovfP <= 1.
  - BS_CHAR: if cnt>0, cnt-- and shadow[cnt-1] <= PAD_CHAR; if cnt==0, ignored. ovfP is not cleared.
  - TERM_CHAR: go to COMMIT.
- Every byte other than BS_CHAR and TERM_CHAR is stored verbatim, including control codes.
- COMMIT, one cycle: b0..b6 <= shadow, with positions >= cnt forced to PAD_CHAR. len <= cnt, ovf <= ovfP, done = 1. Then clear the shadow to PAD_CHAR and set cnt and ovfP to 0.
- COMMIT with dValid=1: the byte is processed as the first byte of the next line, as in IDLE. Next state is RECV or COMMIT. No byte is lost.
- The shadow counter cnt is 3 bits and saturates at 7; it never wraps.
- The outputs b*, len and ovf change only in COMMIT.

## Timing
- Reset values:
  - b0..b6 = PAD_CHAR.
  - len = 0, done = 0, busy = 0, ovf = 0.
  - shadow = PAD_CHAR, cnt = 0, ovfP = 0.
  - State = IDLE.
- Terminator accepted in cycle N: done=1 and the new b*/len/ovf are visible in cycle N+1. Latency is 1.
- busy goes to 1 the cycle after the first non-terminator byte is accepted. It returns to 0 the cycle after the terminator is accepted, i.e. in COMMIT.
- Throughput: one byte per cycle sustained. dValid may be high every cycle, or every other cycle as the sender produces it.
- rst mid-line: the partial line is discarded and all reset values apply the next cycle. No done pulse occurs.
- rst and dValid in the same cycle: rst wins and the byte is dropped.

## Structure
- Shared package recv_string_pkg holds:
  - CHAR_CR, CHAR_BS and CHAR_SP constants, used as parameter defaults.
  - The state enum {IDLE, RECV, COMMIT}.
- Single module, no sub-modules. The shadow buffer and output registers are 7x8 arrays.
- Next-state logic and the byte classification (term / bs / ordinary) are combinational. All state is registered.

## Test plan
- Send "HELLO" + 8'h0d, one byte every other cycle.
  - Cycle after CR: done=1, b0..b4 = 48 45 4C 4C 4F, b5 = b6 = 20, len=5, ovf=0.
- Send "ABCDEFGHIJ" + 0d back-to-back.
  - b0..b6 = "ABCDEFG", len=7, ovf=1.
  - b* unchanged before CR.
- Send "AB", 08, "C", 0d.
  - b0 = 41, b1 = 43, b2..b6 = 20, len=2.
- Send 08, 0d, and separately a lone 0d.
  - Each produces done=1, len=0, all b* = 20.
- Send "XY" 0d followed immediately, next cycle, by "Z" 0d.
  - Two done pulses.
  - Second commit: b0 = 5A, len=1.
  - No byte lost.
- Send "ABC", assert rst for 1 cycle, then "Q" 0d.
  - No done during reset; outputs all 20.
  - Final: b0 = 51, len=1, ovf=0.
